iot_event_encoder: RTL and testbench
====================================

Name: iot_event_encoder

Overview:
- Event source for the active IoT devices monitor. Watches a vector of per-device activity status lines and turns each level change into a single-cycle change/on_off strobe pair. The monitor's up/down counter consumes these strobes directly.
- Sits between the device status inputs and the monitor. Serialises simultaneous device transitions, one event per clock, using round-robin arbitration.
- Keeps a shadow count of active devices. Verification uses it to cross-check the monitor's counter_out.

Parameters:
N_DEV, 8, number of monitored devices (2..64)
ID_W, 3, width of evt_id; equals clog2(N_DEV)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
dev_status  input  N_DEV  per-device activity level (1 = device on); asynchronous to clk
hold  input  1  1 = suppress event emission; edges keep accumulating as pending
change  output  1  registered; 1 for one cycle per emitted event
on_off  output  1  registered; qualified by change; 1 = device turned on (count up), 0 = turned off (count down)
evt_id  output  ID_W  registered; index of the device for the current event; valid when change=1
active_cnt  output  8  registered shadow count: emitted on events minus emitted off events
busy  output  1  registered; 1 when any event is pending

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the sync stages, prev snapshot, pending_on/pending_off masks and the round-robin pointer.
  - Outputs: change=0, on_off=0, evt_id=0, active_cnt=0, busy=0.
  - After rst returns to 1, devices that are already high are seen as rising edges and reported as on events.
- Synchroniser: dev_status passes through a 2-flop synchroniser (s1, then s2). prev holds the last s2 value.
- Edge detection, per clock, for each device i:
  - rise_i = s2_i & ~prev_i
  - fall_i = ~s2_i & prev_i
  - prev takes s2 every cycle.
- Pending update, per device:
  - A rise sets pending_on_i. A fall sets pending_off_i.
  - Cancellation: if a new edge is the opposite type of an existing ungranted pending event on the same device, both are dropped. Net change is zero and no event is emitted.
  - Invariant: pending_on_i and pending_off_i are never both 1.
- Arbitration, when hold=0 and at least one pending bit is set:
  - Grant the lowest index j >= ptr (wrapping modulo N_DEV) with a pending event.
  - Next cycle: change=1, on_off = pending_on_j, evt_id=j.
  - Clear the granted pending bit. Set ptr = (j+1) mod N_DEV.
  - At most one grant per clock.
- When hold=1 or nothing is pending: change=0 next cycle. on_off and evt_id hold their previous values. ptr is unchanged.
- Grant and edge on the same device in the same cycle: the granted bit is cleared and the new edge sets its own pending bit. Cancellation does not apply to the bit being granted.
- Latency: a dev_status change that meets setup at rising edge E1 produces change=1 in the cycle after E4, assuming no contention and hold=0. The bench's allowed window is exactly 4 clocks; no faster path is permitted.
- Throughput: one event per clock. Back-to-back change=1 is legal.
- active_cnt:
  - Increments when an on event is emitted, decrements when an off event is emitted, in the same cycle change is asserted.
  - 8-bit modulo arithmetic. Wrap is unreachable for N_DEV <= 64.
- busy = |(pending_on | pending_off), registered.
- A glitch shorter than one clock may be missed entirely; this is acceptable. Any level held for 2 or more clocks is reported exactly once.

Test Plan:
1. Reset with dev_status=8'h00, then release: change stays 0 for 20 cycles; active_cnt=0, busy=0.
2. Drive dev_status=8'h01 at a known edge: exactly one change pulse 4 clocks later with on_off=1 and evt_id=0; active_cnt=1. Then drive 8'h00: one pulse with on_off=0, evt_id=0; active_cnt=0.
3. Drive dev_status 8'h00 -> 8'hA5: four consecutive change pulses, evt_id=0,2,5,7 in that order, all on_off=1; active_cnt=4; busy drops after the last pulse.
4. hold=1, then dev_status 8'h00 -> 8'h0F -> (10 cycles later) 8'h03, then hold=0:
   - only two pulses, evt_id=0,1, both on_off=1;
   - devices 2 and 3 cancel;
   - active_cnt=2.
5. With ptr=3, device 1 and device 6 pending: grant order is 6 then 1, confirming round-robin wrap.
6. Drive rst=0 mid-burst while dev_status=8'hFF: outputs clear immediately without waiting for a clock edge. After release, 8 on events are emitted; active_cnt=8. A monitor instance driven from change/on_off reads counter_out=8.

Source files
------------

// File: rtl/iot_event_encoder_if.sv
// Event strobe bundle between the device event encoder and the active-device monitor.
// Latency: none (wires only).
// Backpressure: none; every change pulse must be consumed in the cycle it is presented.
//
// Signals:
//   change  - 1 for one cycle per emitted event
//   on_off  - qualified by change: 1 = device turned on, 0 = turned off
//   evt_id  - device index of the current event, valid when change=1
interface iot_event_encoder_if #(
    parameter int ID_W = 3
);
    logic            change;
    logic            on_off;
    logic [ID_W-1:0] evt_id;

    modport master (output change, output on_off, output evt_id);
    modport slave  (input  change, input  on_off, input  evt_id);
endinterface

// File: rtl/iot_event_encoder.sv
// Turns per-device status level changes into one-cycle change/on_off strobes, serialised round-robin.
// Latency: input change sampled at edge E1 emerges as change=1 after edge E4; one event per clock.
// Backpressure: hold=1 stalls emission; edges keep accumulating (and cancelling) as pending.
//
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-low reset
//   dev_status  - per-device activity levels, asynchronous to clk
//   hold        - suppress event emission while 1
//   evt         - change / on_off / evt_id strobe bundle (master side)
//   active_cnt  - shadow count of emitted on events minus emitted off events
//   busy        - 1 while any event is pending
module iot_event_encoder #(
    parameter int N_DEV = 8,
    parameter int ID_W  = $clog2(N_DEV)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DEV-1:0]     dev_status,
    input  logic                 hold,
    iot_event_encoder_if.master  evt,
    output logic [7:0]           active_cnt,
    output logic                 busy
);

    // Synchroniser and edge-detect state
    logic [N_DEV-1:0] s1;
    logic [N_DEV-1:0] s2;
    logic [N_DEV-1:0] prev;

    // Pending event masks; never both set for the same device
    logic [N_DEV-1:0] pend_on;
    logic [N_DEV-1:0] pend_off;

    logic [ID_W-1:0]  ptr;

    // Registered outputs
    logic             change_q;
    logic             on_off_q;
    logic [ID_W-1:0]  evt_id_q;
    logic [7:0]       cnt_q;
    logic             busy_q;

    // Combinational signals
    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] fall;
    logic [N_DEV-1:0] req;
    logic [N_DEV-1:0] gnt_mask;
    logic [N_DEV-1:0] keep_on;
    logic [N_DEV-1:0] keep_off;
    logic [N_DEV-1:0] nxt_on;
    logic [N_DEV-1:0] nxt_off;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    int               idx;

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;
    assign req  = pend_on | pend_off;

    // Round-robin search: first requesting device at or after ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (!hold) begin
            for (int k = 0; k < N_DEV; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_DEV) begin
                    idx = idx - N_DEV;
                end
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(idx);
                end
            end
        end
    end

    assign gnt_mask = {{(N_DEV-1){1'b0}}, gnt_vld} << gnt_id;

    // Granted bits are removed before the new edges are applied, so an
    // opposite edge on the granted device becomes a fresh pending event
    // instead of cancelling the one that is leaving this cycle.
    assign keep_on  = pend_on  & ~gnt_mask;
    assign keep_off = pend_off & ~gnt_mask;

    // An opposite edge on an ungranted pending event annihilates it.
    assign nxt_on   = (keep_on  & ~fall) | (rise & ~keep_off);
    assign nxt_off  = (keep_off & ~rise) | (fall & ~keep_on);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            pend_on  <= '0;
            pend_off <= '0;
            ptr      <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            evt_id_q <= '0;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            s1       <= dev_status;
            s2       <= s1;
            prev     <= s2;
            pend_on  <= nxt_on;
            pend_off <= nxt_off;
            busy_q   <= |(nxt_on | nxt_off);
            change_q <= gnt_vld;
            if (gnt_vld) begin
                on_off_q <= pend_on[gnt_id];
                evt_id_q <= gnt_id;
                ptr      <= (int'(gnt_id) == N_DEV - 1) ? '0 : gnt_id + ID_W'(1);
                cnt_q    <= pend_on[gnt_id] ? cnt_q + 8'd1 : cnt_q - 8'd1;
            end
        end
    end

    assign evt.change = change_q;
    assign evt.on_off = on_off_q;
    assign evt.evt_id = evt_id_q;
    assign active_cnt = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iot_event_encoder.sv
// Self-checking bench for iot_event_encoder: directed scenarios plus random levels/hold.
// Reference model: per-device detected level (3-clock delayed input) versus reported level.
// Expected events are queued at each clock edge and consumed by an independent monitor.
module tb_iot_event_encoder;

    localparam int N_DEV = 8;
    localparam int ID_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_DEV-1:0] dev_status = '0;
    logic             hold = 1'b0;
    logic [7:0]       active_cnt;
    logic             busy;

    iot_event_encoder_if #(.ID_W(ID_W)) evt ();

    iot_event_encoder #(.N_DEV(N_DEV), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_status (dev_status),
        .hold       (hold),
        .evt        (evt),
        .active_cnt (active_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit on;
        int id;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A level sampled at edge k is recognised as pending after edge k+2 and
    // may be granted at edge k+3. A device is pending exactly when its
    // recognised level differs from the level already reported downstream.
    logic [N_DEV-1:0] h1 = '0, h2 = '0, h3 = '0;
    logic [N_DEV-1:0] rep = '0;
    logic [N_DEV-1:0] pend;
    int               m_ptr = 0;
    int               j;
    bit               exp_busy = 1'b0;
    int               exp_cnt = 0;
    int               cyc = 0;
    exp_t             e_new;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            h1 = '0; h2 = '0; h3 = '0; rep = '0;
            m_ptr = 0; exp_busy = 1'b0; exp_cnt = 0;
            exp_q.delete();
        end else begin
            pend = h3 ^ rep;
            if (!hold && pend != '0) begin
                j = -1;
                for (int k = 0; k < N_DEV; k++) begin
                    if (j < 0 && pend[(m_ptr + k) % N_DEV]) j = (m_ptr + k) % N_DEV;
                end
                rep[j]    = h3[j];
                m_ptr     = (j + 1) % N_DEV;
                e_new.on  = h3[j];
                e_new.id  = j;
                e_new.cnt = $countones(rep);
                exp_q.push_back(e_new);
            end
            h3 = h2;
            h2 = h1;
            h1 = dev_status;
            exp_busy = |(h3 ^ rep);
            exp_cnt  = $countones(rep);
        end
    end

    // ---------------- monitor ----------------
    int   pulses = 0;
    int   last_cyc = 0;
    bit   last_on = 1'b0;
    int   last_id = 0;
    logic [7:0] mon_cnt = 8'd0;   // downstream up/down counter driven by the strobes
    int   seen[$];
    int   seen_cyc[$];
    exp_t e_got;

    initial forever begin
        @(negedge clk);
        if (!rst) mon_cnt = 8'd0;
        else if (evt.change) mon_cnt = evt.on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
        chk("evt_present", int'(evt.change), int'(exp_q.size() != 0));
        if (evt.change) begin
            pulses++;
            last_cyc = cyc;
            last_on  = evt.on_off;
            last_id  = int'(evt.evt_id);
            seen.push_back(int'(evt.evt_id));
            seen_cyc.push_back(cyc);
        end
        if (exp_q.size() != 0) begin
            e_got = exp_q.pop_front();
            if (evt.change) begin
                chk("evt_on_off", int'(evt.on_off), int'(e_got.on));
                chk("evt_id", int'(evt.evt_id), e_got.id);
                chk("evt_active_cnt", int'(active_cnt), e_got.cnt);
            end
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("active_cnt", int'(active_cnt), exp_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        dev_status = '0;
        hold = 1'b0;
        tick(3);
        rst = 1'b1;
    endtask

    int base;
    int c0;
    int order3[4] = '{0, 2, 5, 7};

    initial begin
        // 1: reset idle
        tick(3);
        #1;
        chk("reset_change", int'(evt.change), 0);
        chk("reset_evt_id", int'(evt.evt_id), 0);
        chk("reset_on_off", int'(evt.on_off), 0);
        rst = 1'b1;
        base = pulses;
        tick(20);
        #1;
        chk("idle_pulses", pulses - base, 0);
        chk("idle_cnt", int'(active_cnt), 0);
        chk("idle_busy", int'(busy), 0);

        // 2: single device on, then off, with exact latency
        tick(1);
        dev_status = 8'h01;
        c0 = cyc;
        base = pulses;
        tick(8);
        #1;
        chk("t2_on_pulses", pulses - base, 1);
        chk("t2_on_latency", last_cyc - c0, 4);
        chk("t2_on_dir", int'(last_on), 1);
        chk("t2_on_id", last_id, 0);
        chk("t2_on_cnt", int'(active_cnt), 1);
        tick(1);
        dev_status = 8'h00;
        c0 = cyc;
        base = pulses;
        tick(8);
        #1;
        chk("t2_off_pulses", pulses - base, 1);
        chk("t2_off_latency", last_cyc - c0, 4);
        chk("t2_off_dir", int'(last_on), 0);
        chk("t2_off_id", last_id, 0);
        chk("t2_off_cnt", int'(active_cnt), 0);

        // 3: simultaneous edges serialised 0,2,5,7 back to back
        do_reset();
        dev_status = 8'hA5;
        seen.delete();
        seen_cyc.delete();
        base = pulses;
        tick(12);
        #1;
        chk("t3_pulses", pulses - base, 4);
        if (seen.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", seen[i], order3[i]);
            chk("t3_back_to_back", seen_cyc[3] - seen_cyc[0], 3);
        end
        chk("t3_cnt", int'(active_cnt), 4);
        chk("t3_busy", int'(busy), 0);

        // 4: hold with cancellation of devices 2 and 3
        do_reset();
        hold = 1'b1;
        dev_status = 8'h0F;
        seen.delete();
        base = pulses;
        tick(10);
        dev_status = 8'h03;
        tick(6);
        #1;
        chk("t4_hold_pulses", pulses - base, 0);
        chk("t4_hold_busy", int'(busy), 1);
        tick(1);
        hold = 1'b0;
        tick(8);
        #1;
        chk("t4_pulses", pulses - base, 2);
        if (seen.size() == 2) begin
            chk("t4_id0", seen[0], 0);
            chk("t4_id1", seen[1], 1);
        end
        chk("t4_cnt", int'(active_cnt), 2);

        // 5: pointer at 3 with devices 1 and 6 pending -> 6 then 1
        tick(1);
        dev_status = 8'h07;
        tick(8);
        #1;
        chk("t5_prep_id", last_id, 2);
        tick(1);
        hold = 1'b1;
        dev_status = 8'h45;
        tick(6);
        seen.delete();
        hold = 1'b0;
        tick(6);
        #1;
        chk("t5_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("t5_first", seen[0], 6);
            chk("t5_second", seen[1], 1);
        end
        chk("t5_cnt", int'(active_cnt), 3);

        // 6: asynchronous reset mid-burst, then full burst of 8
        tick(1);
        dev_status = 8'hFF;
        tick(5);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_change", int'(evt.change), 0);
        chk("t6_async_on_off", int'(evt.on_off), 0);
        chk("t6_async_evt_id", int'(evt.evt_id), 0);
        chk("t6_async_cnt", int'(active_cnt), 0);
        chk("t6_async_busy", int'(busy), 0);
        tick(3);
        rst = 1'b1;
        seen.delete();
        base = pulses;
        tick(20);
        #1;
        chk("t6_pulses", pulses - base, 8);
        if (seen.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t6_order", seen[i], i);
        end
        chk("t6_cnt", int'(active_cnt), 8);
        chk("t6_monitor_cnt", int'(mon_cnt), 8);

        // Random levels and hold, checked against the model by the monitor
        do_reset();
        for (int it = 0; it < 80; it++) begin
            dev_status = N_DEV'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            tick($urandom_range(1, 6));
        end
        hold = 1'b0;
        tick(30);
        #1;
        chk("rand_busy_end", int'(busy), 0);
        chk("rand_cnt_end", int'(active_cnt), $countones(dev_status));
        chk("rand_monitor_cnt", int'(mon_cnt), $countones(dev_status));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
